ysyx_22050243_gpr_sb: RTL and testbench

YSYX_22050243_GPR_SB -- requirements
Module: ysyx_22050243_gpr_sb

---
 rtl/ysyx_22050243_gpr_sb.sv | 147 ++++++++++++++
 tb/tb_ysyx_22050243_gpr_sb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22050243_gpr_sb.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_gpr_sb
// General-purpose register file with an integrated scoreboard.
//
// Each of the 2**ADDR_WIDTH registers carries a pending bit. Issuing an
// instruction marks its destination pending; writeback stores the data and
// clears the bit. Register 0 is hardwired to zero and is never pending.
// Read ports are combinational, forward same-cycle writeback data and
// report whether the operand is still waiting on a producer.
//
// Ports
//   clk       : single clock, all state updates on its rising edge
//   rst       : synchronous active-high reset (clears data, pending, count)
//   w_en      : writeback enable
//   w_addr    : writeback register index
//   w_data    : writeback data
//   iss_en    : issue enable, marks iss_addr pending
//   iss_addr  : issued destination index
//   r_en      : per-port read enable, bit i = port i
//   r_addr    : packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   r_data    : packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   r_busy    : per-port operand-not-ready flag
//   busy_cnt  : registered number of pending registers
// ---------------------------------------------------------------------------
module ysyx_22050243_gpr_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_READ    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            w_en,
  input  logic [ADDR_WIDTH-1:0]           w_addr,
  input  logic [DATA_WIDTH-1:0]           w_data,
  input  logic                            iss_en,
  input  logic [ADDR_WIDTH-1:0]           iss_addr,
  input  logic [NR_READ-1:0]              r_en,
  input  logic [NR_READ*ADDR_WIDTH-1:0]   r_addr,
  output logic [NR_READ*DATA_WIDTH-1:0]   r_data,
  output logic [NR_READ-1:0]              r_busy,
  output logic [ADDR_WIDTH:0]             busy_cnt
);

  localparam int NR_REG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] gpr_r [NR_REG];
  logic [NR_REG-1:0]     pend_r;
  logic [ADDR_WIDTH:0]   busy_cnt_r;
  logic [ADDR_WIDTH:0]   cnt_next_s;

  logic set_s;    // issue targets a real register
  logic clr_s;    // writeback targets a real register
  logic rise_s;   // a pending bit goes 0->1 this cycle
  logic fall_s;   // a pending bit goes 1->0 this cycle

  assign set_s = iss_en && (iss_addr != '0);
  assign clr_s = w_en && (w_addr != '0);

  // Pending-bit transitions; a same-index issue overrides the writeback clear.
  always_comb begin
    rise_s = 1'b0;
    fall_s = 1'b0;
    if (set_s) begin
      rise_s = ~pend_r[iss_addr];
    end else begin
      rise_s = 1'b0;
    end
    if (clr_s && !(set_s && (iss_addr == w_addr))) begin
      fall_s = pend_r[w_addr];
    end else begin
      fall_s = 1'b0;
    end
  end

  // Next pending count, saturating at both ends as a safety net.
  always_comb begin
    cnt_next_s = busy_cnt_r;
    if (rise_s && !fall_s && (busy_cnt_r != CNT_MAX)) begin
      cnt_next_s = busy_cnt_r + CNT_ONE;
    end else if (fall_s && !rise_s && (busy_cnt_r != '0)) begin
      cnt_next_s = busy_cnt_r - CNT_ONE;
    end else begin
      cnt_next_s = busy_cnt_r;
    end
  end

  // Data registers: reset clears all, writeback stores to nonzero indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) begin
        gpr_r[i] <= '0;
      end
    end else if (clr_s) begin
      gpr_r[w_addr] <= w_data;
    end
  end

  // Pending bits and their count; the issue is applied after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r     <= '0;
      busy_cnt_r <= '0;
    end else begin
      if (clr_s) begin
        pend_r[w_addr] <= 1'b0;
      end
      if (set_s) begin
        pend_r[iss_addr] <= 1'b1;
      end
      busy_cnt_r <= cnt_next_s;
    end
  end

  assign busy_cnt = busy_cnt_r;

  for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] rd_s;
    logic                  rb_s;

    assign ra_s  = r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit_s = w_en && (w_addr == ra_s);

    // Read mux with writeback forwarding; a forwarded operand is ready.
    always_comb begin
      rd_s = '0;
      rb_s = 1'b0;
      if (!r_en[gi] || (ra_s == '0)) begin
        rd_s = '0;
        rb_s = 1'b0;
      end else if (hit_s) begin
        rd_s = w_data;
        rb_s = 1'b0;
      end else begin
        rd_s = gpr_r[ra_s];
        rb_s = pend_r[ra_s];
      end
    end

    assign r_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_s;
    assign r_busy[gi] = rb_s;
  end

endmodule

// File: tb/tb_ysyx_22050243_gpr_sb.sv
module tb_ysyx_22050243_gpr_sb;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;

  logic           clk;
  logic           rst;
  logic           w_en;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_data;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic [NR-1:0]  r_en;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;
  logic [NR-1:0]  r_busy;
  logic [AW:0]    busy_cnt;

  int errors;
  int checks;

  ysyx_22050243_gpr_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .r_en(r_en), .r_addr(r_addr),
    .r_data(r_data), .r_busy(r_busy), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then leave a settle gap before new inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0; iss_en = 1'b0; w_addr = '0; iss_addr = '0; w_data = '0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    r_en[p] = 1'b1;
    r_addr[p*AW +: AW] = a;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b0;
    w_en = 1'b1; w_addr = 5'd5; w_data = 64'hDEAD; step();
    idle(); rst = 1'b1; step(); step();
    rst = 1'b0; rd(0, 5'd5); #1;
    checks++; if (r_data[63:0] !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", r_data[63:0], 64'h0); end
    checks++; if (r_busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", r_busy[0], 1'b0); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected %0d", busy_cnt, 0); end
  endtask

  task automatic test_bypass();
    w_en = 1'b1; w_addr = 5'd3; w_data = 64'h1234;
    rd(0, 5'd3); rd(1, 5'd3); #1;
    checks++; if (r_data[63:0] !== 64'h1234) begin errors++; $display("FAIL bypass_p0: got %h expected %h", r_data[63:0], 64'h1234); end
    checks++; if (r_data[127:64] !== 64'h1234) begin errors++; $display("FAIL bypass_p1: got %h expected %h", r_data[127:64], 64'h1234); end
    step(); idle(); #1;
    checks++; if (r_data[63:0] !== 64'h1234) begin errors++; $display("FAIL stored_p0: got %h expected %h", r_data[63:0], 64'h1234); end
    r_en[1] = 1'b0; #1;
    checks++; if (r_data[127:64] !== 64'h0) begin errors++; $display("FAIL ren_off_p1: got %h expected %h", r_data[127:64], 64'h0); end
  endtask

  task automatic test_x0();
    w_en = 1'b1; w_addr = 5'd0; w_data = 64'hFFFF;
    iss_en = 1'b1; iss_addr = 5'd0; rd(0, 5'd0); #1;
    checks++; if (r_data[63:0] !== 64'h0) begin errors++; $display("FAIL x0_bypass: got %h expected %h", r_data[63:0], 64'h0); end
    step(); idle(); #1;
    checks++; if (r_data[63:0] !== 64'h0) begin errors++; $display("FAIL x0_stored: got %h expected %h", r_data[63:0], 64'h0); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL x0_cnt: got %0d expected %0d", busy_cnt, 0); end
  endtask

  task automatic test_issue_clear();
    iss_en = 1'b1; iss_addr = 5'd7; step(); idle(); rd(0, 5'd7); #1;
    checks++; if (r_busy[0] !== 1'b1) begin errors++; $display("FAIL iss_busy: got %b expected %b", r_busy[0], 1'b1); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL iss_cnt: got %0d expected %0d", busy_cnt, 1); end
    w_en = 1'b1; w_addr = 5'd7; w_data = 64'hAA; #1;
    checks++; if (r_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_busy: got %b expected %b", r_busy[0], 1'b0); end
    checks++; if (r_data[63:0] !== 64'hAA) begin errors++; $display("FAIL wb_data: got %h expected %h", r_data[63:0], 64'hAA); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL wb_cnt_hold: got %0d expected %0d", busy_cnt, 1); end
    step(); idle(); #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL wb_cnt: got %0d expected %0d", busy_cnt, 0); end
    checks++; if (r_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_busy_after: got %b expected %b", r_busy[0], 1'b0); end
  endtask

  task automatic test_same_cycle();
    iss_en = 1'b1; iss_addr = 5'd9; step(); idle();
    iss_en = 1'b1; iss_addr = 5'd9; w_en = 1'b1; w_addr = 5'd9; w_data = 64'h55;
    step(); idle(); rd(0, 5'd9); #1;
    checks++; if (r_data[63:0] !== 64'h55) begin errors++; $display("FAIL same_data: got %h expected %h", r_data[63:0], 64'h55); end
    checks++; if (r_busy[0] !== 1'b1) begin errors++; $display("FAIL same_busy: got %b expected %b", r_busy[0], 1'b1); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL same_cnt: got %0d expected %0d", busy_cnt, 1); end
    // clear x9 while issuing x12: count stays at 1
    iss_en = 1'b1; iss_addr = 5'd12; w_en = 1'b1; w_addr = 5'd9; w_data = 64'h66;
    step(); idle(); rd(1, 5'd12); #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL swap_cnt: got %0d expected %0d", busy_cnt, 1); end
    checks++; if (r_busy !== 2'b10) begin errors++; $display("FAIL swap_busy: got %b expected %b", r_busy, 2'b10); end
    w_en = 1'b1; w_addr = 5'd12; w_data = 64'h77; step(); idle(); #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL swap_clr_cnt: got %0d expected %0d", busy_cnt, 0); end
    checks++; if (r_data[127:64] !== 64'h77) begin errors++; $display("FAIL swap_clr_data: got %h expected %h", r_data[127:64], 64'h77); end
  endtask

  task automatic test_back_to_back();
    w_en = 1'b1; w_addr = 5'd20; w_data = 64'hA1; step();
    w_data = 64'hB2; rd(0, 5'd20); #1;
    checks++; if (r_data[63:0] !== 64'hB2) begin errors++; $display("FAIL b2b_bypass: got %h expected %h", r_data[63:0], 64'hB2); end
    step(); w_addr = 5'd21; w_data = 64'hC3; #1;
    checks++; if (r_data[63:0] !== 64'hB2) begin errors++; $display("FAIL b2b_other: got %h expected %h", r_data[63:0], 64'hB2); end
    step(); idle(); rd(1, 5'd21); #1;
    checks++; if (r_data[127:64] !== 64'hC3) begin errors++; $display("FAIL b2b_x21: got %h expected %h", r_data[127:64], 64'hC3); end
  endtask

  task automatic test_reset_priority();
    for (int i = 1; i <= 4; i++) begin
      iss_en = 1'b1; iss_addr = AW'(i); step();
    end
    idle(); #1;
    checks++; if (busy_cnt !== 6'd4) begin errors++; $display("FAIL rp_cnt4: got %0d expected %0d", busy_cnt, 4); end
    rst = 1'b1; w_en = 1'b1; w_addr = 5'd2; w_data = 64'h99; rd(0, 5'd2); rd(1, 5'd9); #1;
    checks++; if (r_data[63:0] !== 64'h99) begin errors++; $display("FAIL rp_bypass: got %h expected %h", r_data[63:0], 64'h99); end
    step(); rst = 1'b0; idle(); #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL rp_cnt0: got %0d expected %0d", busy_cnt, 0); end
    checks++; if (r_data[63:0] !== 64'h0) begin errors++; $display("FAIL rp_x2: got %h expected %h", r_data[63:0], 64'h0); end
    checks++; if (r_busy !== 2'b00) begin errors++; $display("FAIL rp_busy: got %b expected %b", r_busy, 2'b00); end
    checks++; if (r_data[127:64] !== 64'h0) begin errors++; $display("FAIL rp_x9: got %h expected %h", r_data[127:64], 64'h0); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; r_en = '0; r_addr = '0; idle();
    step(); step();
    test_reset();
    test_bypass();
    test_x0();
    test_issue_clear();
    test_same_cycle();
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
